// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, default divider and the
// receiver state encoding.
package uart_pkg;

  localparam int OVERSAMPLE           = 4;
  localparam int START_SAMPLE_QTICKS  = 2;
  localparam int DEFAULT_CLOCK_DIVIDE = 271;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE      = ST_IDLE,
    RX_START     = ST_START,
    RX_DATA      = ST_DATA,
    RX_STOP      = ST_STOP,
    RX_WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Clearable divider producing a one-clock qtick every CLOCK_DIVIDE clocks
// (one quarter bit period); shared by the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = DEFAULT_CLOCK_DIVIDE
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic qtick
);

  localparam int CW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_DIVIDE - 1);

  logic [CW-1:0] count_q, count_d;

  // A clear restarts the count at zero so the first qtick lands CLOCK_DIVIDE clocks later.
  always_comb begin
    qtick   = (count_q == LAST);
    count_d = count_q + 1'b1;
    if (clear || qtick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 4x oversampling; pushes good bytes into the RX FIFO
// and flags framing errors and overruns.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = DEFAULT_CLOCK_DIVIDE,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic                 rx_fifo_full,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_push,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int QW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [QW-1:0] START_LAST = QW'(START_SAMPLE_QTICKS - 1);
  localparam logic [QW-1:0] BIT_LAST   = QW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [QW-1:0]        qcount_q, qcount_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 push_q, push_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 qtick;
  logic                 div_clear;

  uart_baud_tick #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_baud_tick (
    .clk   (clk),
    .resetn(resetn),
    .clear (div_clear),
    .qtick (qtick)
  );

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], rx};
    state_d   = state_q;
    qcount_d  = qcount_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    push_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    busy_d    = busy_q;
    div_clear = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d   = RX_START;
          qcount_d  = '0;
          div_clear = 1'b1;
          busy_d    = 1'b1;
        end
      end

      // Mid start bit: a line that has already gone high again was a glitch.
      RX_START: begin
        if (qtick) begin
          if (qcount_q == START_LAST) begin
            qcount_d = '0;
            if (!rx_s) begin
              state_d   = RX_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = RX_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            qcount_d = qcount_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (qtick) begin
          if (qcount_q == BIT_LAST) begin
            qcount_d = '0;
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) begin
              state_d = RX_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            qcount_d = qcount_q + 1'b1;
          end
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
      RX_STOP: begin
        if (qtick) begin
          if (qcount_q == BIT_LAST) begin
            qcount_d = '0;
            if (rx_s) begin
              state_d = RX_IDLE;
              busy_d  = 1'b0;
              if (rx_fifo_full) begin
                ovr_d = 1'b1;
              end else begin
                push_d    = 1'b1;
                rx_byte_d = shift_q;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_WAIT_HIGH;
            end
          end else begin
            qcount_d = qcount_q + 1'b1;
          end
        end
      end

      RX_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = RX_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = RX_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= 2'b11;
      state_q   <= RX_IDLE;
      qcount_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      qcount_q  <= qcount_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      push_q    <= push_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_push   = push_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: per-cycle expectations from a frame-level
// model, plus hand-computed checks that pin the model's timing and values.
module tb_uart_rx;

  localparam int CD       = 4;
  localparam int BITC     = 4 * CD;
  localparam int FRAMEC   = 10 * BITC;
  // A start edge driven just after negedge n reaches rx_s two clocks after
  // capture, so the receiver leaves IDLE at T0 = n+3; the stop sample is at
  // T0+152 and the pulse is visible at negedge n+155 (FIFO captures at T0+153).
  localparam int BUSY_ON  = 3;
  localparam int PUSH_LAT = 3 + 38 * CD;
  localparam int NCYC     = 4096;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_push;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLOCK_DIVIDE(CD),
    .DATA_BITS   (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx          (rx),
    .rx_fifo_full(rx_fifo_full),
    .rx_byte     (rx_byte),
    .rx_push     (rx_push),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       exp_push [NCYC];
  logic       exp_ferr [NCYC];
  logic       exp_ovr  [NCYC];
  logic       exp_busy [NCYC];
  logic [7:0] exp_byte [NCYC];

  int         vectors = 0;
  int         miscompares = 0;
  logic       compare_en = 1'b0;
  logic [7:0] model_byte = 8'h00;
  int         push_cyc[$];
  logic [7:0] push_val[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Per-cycle comparison against the model; also logs events for the literal checks.
  always @(negedge clk) begin
    if (compare_en && cyc < NCYC) begin
      if (!resetn) model_byte = 8'h00;
      else if (exp_push[cyc]) model_byte = exp_byte[cyc];
      check_output("rx_push", {31'd0, rx_push}, {31'd0, exp_push[cyc]});
      check_output("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr[cyc]});
      check_output("overrun", {31'd0, overrun}, {31'd0, exp_ovr[cyc]});
      check_output("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
      check_output("rx_byte", {24'd0, rx_byte}, {24'd0, model_byte});
      if (rx_push) begin
        push_cyc.push_back(cyc);
        push_val.push_back(rx_byte);
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic set_busy(input int from, input int upto);
    for (int c = from; c < upto; c++) begin
      if (c >= 0 && c < NCYC) exp_busy[c] = 1'b1;
    end
  endtask

  // Frame-level model: busy window, then exactly one outcome at the stop sample.
  task automatic schedule_frame(input int n, input logic [7:0] data, input logic stop_bit,
                                input logic full, input int ncycles);
    int t;
    t = n + PUSH_LAT;
    if (stop_bit) begin
      set_busy(n + BUSY_ON, t);
      if (t < NCYC) begin
        if (full) exp_ovr[t] = 1'b1;
        else begin
          exp_push[t] = 1'b1;
          exp_byte[t] = data;
        end
      end
    end else begin
      set_busy(n + BUSY_ON, n + ncycles + 3);
      if (t < NCYC) exp_ferr[t] = 1'b1;
    end
  endtask

  // Drives start, LSB-first data, then the stop level held for the remaining cycles.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input logic full, input int ncycles, output int n);
    int bitpos;
    n = 0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) begin
        n = cyc;
        schedule_frame(n, data, stop_bit, full, ncycles);
      end
      bitpos = c / BITC;
      if (bitpos == 0) rx = 1'b0;
      else if (bitpos <= 8) rx = data[bitpos-1];
      else rx = stop_bit;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  int n1, n2, g, r, dummy;

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      exp_push[c] = 1'b0;
      exp_ferr[c] = 1'b0;
      exp_ovr[c]  = 1'b0;
      exp_busy[c] = 1'b0;
      exp_byte[c] = 8'h00;
    end

    #2;
    check_output("reset rx_byte", {24'd0, rx_byte}, 32'h0);
    check_output("reset rx_push", {31'd0, rx_push}, 32'h0);
    check_output("reset busy", {31'd0, busy}, 32'h0);
    idle(3);
    #1;
    resetn = 1'b1;
    compare_en = 1'b1;
    idle(10);

    // Good frame 0xA5.
    apply_stimulus(8'hA5, 1'b1, 1'b0, FRAMEC, n1);
    idle(40);

    // One-quarter-bit glitch: rejected at the start sample, 8 clks after T0.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) begin
        g = cyc;
        set_busy(g + BUSY_ON, g + BUSY_ON + 2 * CD);
      end
      rx = 1'b0;
    end
    @(negedge clk);
    #1;
    rx = 1'b1;
    while (cyc < g + 10) @(negedge clk);
    check_output("glitch busy before", {31'd0, busy}, 32'h1);
    @(negedge clk);
    check_output("glitch busy after", {31'd0, busy}, 32'h0);
    idle(30);

    // 0x3C with a low stop bit, then a 20-bit-time break.
    apply_stimulus(8'h3C, 1'b0, 1'b0, FRAMEC + 20 * BITC, dummy);
    @(negedge clk);
    #1;
    rx = 1'b1;
    idle(40);

    // Overrun on 0x77, then a normal 0x12.
    #1;
    rx_fifo_full = 1'b1;
    apply_stimulus(8'h77, 1'b1, 1'b1, FRAMEC, dummy);
    idle(20);
    check_output("rx_byte kept after overrun", {24'd0, rx_byte}, 32'hA5);
    #1;
    rx_fifo_full = 1'b0;
    idle(20);
    apply_stimulus(8'h12, 1'b1, 1'b0, FRAMEC, dummy);
    idle(40);

    // Back-to-back 0x00 then 0xFF.
    apply_stimulus(8'h00, 1'b1, 1'b0, FRAMEC, dummy);
    apply_stimulus(8'hFF, 1'b1, 1'b0, FRAMEC, n2);
    idle(40);

    // Reset in the middle of data bit 4 of a frame.
    apply_stimulus(8'h96, 1'b1, 1'b0, 5 * BITC + BITC / 2, dummy);
    @(negedge clk);
    #1;
    r = cyc;
    for (int c = r + 1; c < NCYC; c++) begin
      exp_push[c] = 1'b0;
      exp_ferr[c] = 1'b0;
      exp_ovr[c]  = 1'b0;
      exp_busy[c] = 1'b0;
    end
    resetn = 1'b0;
    rx = 1'b1;
    #1;
    check_output("midframe reset busy", {31'd0, busy}, 32'h0);
    check_output("midframe reset rx_byte", {24'd0, rx_byte}, 32'h0);
    check_output("midframe reset pulses", {29'd0, rx_push, frame_err, overrun}, 32'h0);
    idle(3);
    #1;
    resetn = 1'b1;
    idle(40);
    apply_stimulus(8'h5A, 1'b1, 1'b0, FRAMEC, dummy);
    idle(40);

    // Hand-computed expectations that pin the model.
    check_output("push count", push_cyc.size(), 32'd5);
    check_output("frame_err count", ferr_cnt, 32'd1);
    check_output("overrun count", ovr_cnt, 32'd1);
    if (push_cyc.size() >= 5) begin
      check_output("first push latency", push_cyc[0] - n1, 32'd155);
      check_output("first byte", {24'd0, push_val[0]}, 32'hA5);
      check_output("byte after overrun", {24'd0, push_val[1]}, 32'h12);
      check_output("back-to-back byte 1", {24'd0, push_val[2]}, 32'h00);
      check_output("back-to-back byte 2", {24'd0, push_val[3]}, 32'hFF);
      check_output("back-to-back spacing", push_cyc[3] - push_cyc[2], 32'd160);
      check_output("second frame latency", push_cyc[3] - n2, 32'd155);
      check_output("byte after reset", {24'd0, push_val[4]}, 32'h5A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: deserialises the `rx` pin into bytes and pushes them into the RX FIFO inside the UART FIFO wrapper.
- Sits directly upstream of that RX FIFO and therefore of the memory-mapped UART register at 0x80020008.
- Uses 4x oversampling with the same CLOCK_DIVIDE convention as the rest of the UART: CLOCK_DIVIDE = f_clk / (4 * baud), default 271.
- Also reports framing errors and overruns.

Parameters:
- CLOCK_DIVIDE, 271, system clocks per quarter bit period; must be >= 2.
- DATA_BITS, 8, payload bits per frame; LSB first.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- rx_fifo_full  input  1  downstream RX FIFO cannot accept a push this cycle.
- rx_byte  output  8  received byte; valid when rx_push=1; holds its last value otherwise.
- rx_push  output  1  one-cycle FIFO write strobe.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because rx_fifo_full=1.
- busy  output  1  high from start-bit detection until the frame completes or is abandoned.

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - rx_byte=0; rx_push=0; frame_err=0; overrun=0; busy=0.
  - Synchroniser flops=1; state=IDLE; counters=0.
- Synchronisation: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Tick generator: divider counter of width $clog2(CLOCK_DIVIDE).
  - Produces qtick (one clk wide) every CLOCK_DIVIDE clocks.
  - Cleared on entry to START, so bit phase is aligned to the detected falling edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START; divider and quarter count cleared; busy<=1.
  - START: on the 2nd qtick (mid start bit), sample rx_s.
    - rx_s==0 -> DATA; bit index=0.
    - rx_s==1 -> IDLE; busy<=0; glitch rejected, no pulse.
  - DATA: every 4th qtick, shift rx_s into the shift register MSB, LSB-first. After DATA_BITS samples -> STOP.
  - STOP: on the 4th qtick, sample rx_s.
    - rx_s==1 and rx_fifo_full==0: rx_byte<=shift register; rx_push<=1 for one cycle.
    - rx_s==1 and rx_fifo_full==1: overrun<=1 for one cycle; byte discarded; rx_byte unchanged.
    - In both rx_s==1 cases: next state is IDLE, busy<=0.
    - rx_s==0: frame_err<=1 for one cycle; no push; next state is WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE with busy<=0. This prevents a held-low break from generating repeated frames.
- Timing, measured from the first clk at which rx_s==0 in IDLE (T0):
  - Start sample at T0 + 2*CLOCK_DIVIDE.
  - Data bit k sampled at T0 + (2+4*(k+1))*CLOCK_DIVIDE.
  - Stop sample at T0 + 38*CLOCK_DIVIDE.
  - rx_push/frame_err/overrun registered 1 clk after the stop sample.
- Pin-to-rx_s latency is 2 clks.
- Back-to-back frames: returning to IDLE at mid stop bit allows a start bit immediately after a nominal stop bit to be detected with no lost frame.
- rx_push, frame_err and overrun are mutually exclusive. Each is at most one pulse per frame.
- rx_fifo_full is sampled only in the rx_s==1 STOP-sample cycle. The FIFO must accept any push issued while rx_fifo_full==0.
- Reset asserted mid-frame: immediate return to reset values; no pulse is emitted. After release, a frame already in progress may be received as garbage or rejected; no recovery is guaranteed.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (3-bit localparams).
  - OVERSAMPLE=4.
  - START_SAMPLE_QTICKS=2.
  - Default CLOCK_DIVIDE=271.
- One natural sub-module: uart_baud_tick. It is the clearable divider producing qtick, and the future uart_tx reuses it.
- The synchroniser stays inline.

Test Plan:
All scenarios use CLOCK_DIVIDE=4, i.e. 16 clks per bit.
- Byte 0xA5 sent with a correct stop bit -> exactly one rx_push with rx_byte=0xA5, at T0+153 clks; busy high across the frame; frame_err=overrun=0.
- rx pulsed low for 4 clks (1 quarter bit), then held high -> no rx_push and no error pulse; busy falls 8 clks after T0.
- Frame 0x3C with stop bit 0, then rx held low for 20 bit times, then high -> one frame_err pulse; no rx_push; no further frames while low; busy drops only after rx_s returns high.
- rx_fifo_full=1 during frame 0x77 -> one overrun pulse; no rx_push; rx_byte keeps its previous value. Next frame 0x12 with full=0 -> rx_push, rx_byte=0x12.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop bit -> two rx_push pulses, 160 clks apart, values 0x00 and 0xFF.
- resetn pulsed low at data bit 4 of a frame -> all outputs reset asynchronously. After release with the line idle, frame 0x5A is received correctly.
